// File: rtl/regfile_scoreboard_pkg.sv
// Shared widths, address type and helpers for the register file and its busy scoreboard.
package regfile_scoreboard_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    typedef logic [XLEN-1:0] xdata_t;
    typedef logic [AW-1:0]   raddr_t;

    localparam raddr_t REG_ZERO = '0;

    // One-hot select of a register; x0 never selects anything, so x0 can never be written or marked busy.
    function automatic logic [NREGS-1:0] reg_onehot(input raddr_t a);
        reg_onehot = '0;
        if (a != REG_ZERO) begin
            reg_onehot[a] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/regfile_scoreboard_reg_scoreboard.sv
// Per-register busy bits for pending loads: operand-ready and WAW hazard terms, set/clear with set priority.
module reg_scoreboard
    import regfile_scoreboard_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  raddr_t rs1_addr,
    input  raddr_t rs2_addr,
    input  logic   rs1_used,
    input  logic   rs2_used,
    input  logic   issue_valid,
    input  raddr_t issue_rd,
    input  logic   issue_pend,
    input  logic   wb_en,
    input  raddr_t wb_addr,
    input  logic   wb_clr,
    input  logic   stall,
    output logic   rs1_stall,
    output logic   rs2_stall,
    output logic   waw_stall
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_clr_vec;
    logic [NREGS-1:0] w_set_vec;

    assign w_clr_vec = (wb_en && wb_clr) ? reg_onehot(wb_addr) : '0;
    assign w_set_vec = (issue_valid && issue_pend && !stall) ? reg_onehot(issue_rd) : '0;

    // A retiring load makes its register ready in the same cycle, matching the bypass on the data path.
    assign rs1_stall = rs1_used && r_busy[rs1_addr] && !w_clr_vec[rs1_addr];
    assign rs2_stall = rs2_used && r_busy[rs2_addr] && !w_clr_vec[rs2_addr];
    assign waw_stall = issue_valid && issue_pend && (issue_rd != REG_ZERO)
                       && r_busy[issue_rd] && !w_clr_vec[issue_rd];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr_vec) | w_set_vec;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// 32x32 register file with x0 hardwired to zero, writeback bypass to ID operands,
// and a stall output driven by the load-busy scoreboard.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  raddr_t rs1_addr,
    input  raddr_t rs2_addr,
    input  logic   rs1_used,
    input  logic   rs2_used,
    output xdata_t rs1_data,
    output xdata_t rs2_data,
    input  logic   issue_valid,
    input  raddr_t issue_rd,
    input  logic   issue_pend,
    input  logic   wb_en,
    input  raddr_t wb_addr,
    input  xdata_t wb_data,
    input  logic   wb_clr,
    output logic   stall
);

    xdata_t r_regs [NREGS];
    logic   w_rs1_stall;
    logic   w_rs2_stall;
    logic   w_waw_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_en && (wb_addr != REG_ZERO)) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    always_comb begin
        rs1_data = r_regs[rs1_addr];
        if (rs1_addr == REG_ZERO) begin
            rs1_data = '0;
        end else if (wb_en && (wb_addr == rs1_addr)) begin
            rs1_data = wb_data;
        end
    end

    always_comb begin
        rs2_data = r_regs[rs2_addr];
        if (rs2_addr == REG_ZERO) begin
            rs2_data = '0;
        end else if (wb_en && (wb_addr == rs2_addr)) begin
            rs2_data = wb_data;
        end
    end

    assign stall = w_rs1_stall || w_rs2_stall || w_waw_stall;

    // stall feeds back only into the busy-set enable, never into the hazard terms themselves.
    reg_scoreboard u_sb (
        .clk         (clk),
        .rst         (rst),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_used    (rs1_used),
        .rs2_used    (rs2_used),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_pend  (issue_pend),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_clr      (wb_clr),
        .stall       (stall),
        .rs1_stall   (w_rs1_stall),
        .rs2_stall   (w_rs2_stall),
        .waw_stall   (w_waw_stall)
    );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: each cycle's expected outputs are queued with the stimulus and checked at the falling edge.
module tb_regfile_scoreboard;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1_addr, rs2_addr, issue_rd, wb_addr;
    logic        rs1_used, rs2_used, issue_valid, issue_pend, wb_en, wb_clr;
    logic [31:0] wb_data, rs1_data, rs2_data;
    logic        stall;

    typedef struct {
        string       tag;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        stall;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests;
    int   n_fail;

    regfile_scoreboard dut (
        .clk         (clk),
        .rst         (rst),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_used    (rs1_used),
        .rs2_used    (rs2_used),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_pend  (issue_pend),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .wb_clr      (wb_clr),
        .stall       (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rs1_addr = 5'd0; rs2_addr = 5'd0; rs1_used = 1'b0; rs2_used = 1'b0;
        issue_valid = 1'b0; issue_rd = 5'd0; issue_pend = 1'b0;
        wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0; wb_clr = 1'b0;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic rd(input logic [4:0] a1, input logic u1, input logic [4:0] a2, input logic u2);
        rs1_addr = a1; rs1_used = u1; rs2_addr = a2; rs2_used = u2;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d, input logic clr);
        wb_en = 1'b1; wb_addr = a; wb_data = d; wb_clr = clr;
    endtask

    task automatic issue(input logic [4:0] r, input logic pend);
        issue_valid = 1'b1; issue_rd = r; issue_pend = pend;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] e1, input logic [31:0] e2, input logic es);
        exp_t e;
        e.tag = tag; e.rs1 = e1; e.rs2 = e2; e.stall = es;
        exp_q.push_back(e);
    endtask

    task automatic sample_now();
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("queue_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({e.tag, ".rs1"}, rs1_data, e.rs1);
            chk({e.tag, ".rs2"}, rs2_data, e.rs2);
            chk({e.tag, ".stall"}, {31'd0, stall}, {31'd0, e.stall});
        end
    endtask

    task automatic sample();
        @(negedge clk);
        sample_now();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        idle();

        // 1: reset state
        rd(5'd5, 1'b1, 5'd31, 1'b1);
        expect_out("reset", 32'd0, 32'd0, 1'b0); sample();
        #1 rst = 1'b0;
        next_cyc(); rd(5'd5, 1'b1, 5'd31, 1'b1);
        expect_out("post_reset", 32'd0, 32'd0, 1'b0); sample();

        // 2: x0 write discarded, no bypass onto x0
        next_cyc(); wb(5'd0, 32'hDEADBEEF, 1'b0); rd(5'd0, 1'b1, 5'd0, 1'b1);
        expect_out("x0_wr_same", 32'd0, 32'd0, 1'b0); sample();
        next_cyc(); rd(5'd0, 1'b1, 5'd0, 1'b1);
        expect_out("x0_wr_next", 32'd0, 32'd0, 1'b0); sample();

        // 3: bypass then stored value
        next_cyc(); wb(5'd7, 32'h12345678, 1'b0); rd(5'd7, 1'b1, 5'd5, 1'b1);
        expect_out("byp_x7", 32'h12345678, 32'd0, 1'b0); sample();
        next_cyc(); wb(5'd31, 32'hCAFEF00D, 1'b0); rd(5'd7, 1'b1, 5'd31, 1'b1);
        expect_out("x7_held_x31_byp", 32'h12345678, 32'hCAFEF00D, 1'b0); sample();
        next_cyc(); rd(5'd31, 1'b1, 5'd7, 1'b1);
        expect_out("x31_held", 32'hCAFEF00D, 32'h12345678, 1'b0); sample();

        // 4: load to x9 stalls a reader until its writeback cycle
        next_cyc(); issue(5'd9, 1'b1);
        expect_out("ld9_issue", 32'd0, 32'd0, 1'b0); sample();
        next_cyc(); rd(5'd0, 1'b0, 5'd9, 1'b0);
        expect_out("x9_unused", 32'd0, 32'd0, 1'b0); sample();
        for (int i = 0; i < 3; i++) begin
            next_cyc(); rd(5'd0, 1'b0, 5'd9, 1'b1);
            issue(5'd10, 1'b1);
            if (i == 1) begin
                wb_clr = 1'b1; wb_addr = 5'd9;
            end
            expect_out($sformatf("ld9_stall%0d", i), 32'd0, 32'd0, 1'b1); sample();
        end
        next_cyc(); rd(5'd0, 1'b0, 5'd9, 1'b1); wb(5'd9, 32'h000000A5, 1'b1);
        expect_out("ld9_wb", 32'd0, 32'h000000A5, 1'b0); sample();
        next_cyc(); rd(5'd10, 1'b1, 5'd9, 1'b1);
        expect_out("ld9_after", 32'd0, 32'h000000A5, 1'b0); sample();

        // load to x0 never marks busy
        next_cyc(); issue(5'd0, 1'b1);
        expect_out("ld0_issue", 32'd0, 32'd0, 1'b0); sample();
        next_cyc(); rd(5'd0, 1'b1, 5'd0, 1'b1); issue(5'd0, 1'b1);
        expect_out("ld0_again", 32'd0, 32'd0, 1'b0); sample();

        // 5: WAW guard and set-wins on a same-cycle clear
        next_cyc(); issue(5'd3, 1'b1);
        expect_out("ld3_issue", 32'd0, 32'd0, 1'b0); sample();
        next_cyc(); issue(5'd3, 1'b1);
        expect_out("ld3_waw", 32'd0, 32'd0, 1'b1); sample();
        next_cyc(); issue(5'd3, 1'b1); wb(5'd3, 32'h00000033, 1'b1);
        expect_out("ld3_waw_clr", 32'd0, 32'd0, 1'b0); sample();
        next_cyc(); rd(5'd3, 1'b1, 5'd0, 1'b0);
        expect_out("ld3_set_wins", 32'h00000033, 32'd0, 1'b1); sample();
        next_cyc(); rd(5'd3, 1'b1, 5'd0, 1'b0); wb(5'd3, 32'h00000044, 1'b1);
        expect_out("ld3_wb2", 32'h00000044, 32'd0, 1'b0); sample();
        next_cyc(); rd(5'd3, 1'b1, 5'd3, 1'b1);
        expect_out("ld3_done", 32'h00000044, 32'h00000044, 1'b0); sample();

        // clear of a non-busy register is a plain write
        next_cyc(); wb(5'd12, 32'h00000012, 1'b1);
        expect_out("clr_idle", 32'd0, 32'd0, 1'b0); sample();
        next_cyc(); rd(5'd12, 1'b1, 5'd12, 1'b1);
        expect_out("clr_idle_rd", 32'h00000012, 32'h00000012, 1'b0); sample();

        // 6: async reset in the middle of a load stall
        next_cyc(); issue(5'd4, 1'b1);
        expect_out("ld4_issue", 32'd0, 32'd0, 1'b0); sample();
        next_cyc(); rd(5'd4, 1'b1, 5'd7, 1'b1);
        expect_out("ld4_stall", 32'd0, 32'h12345678, 1'b1); sample();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        expect_out("rst_async", 32'd0, 32'd0, 1'b0); sample_now();
        @(negedge clk);
        rst = 1'b0;
        next_cyc(); rd(5'd4, 1'b1, 5'd31, 1'b1);
        expect_out("after_rst", 32'd0, 32'd0, 1'b0); sample();

        if (exp_q.size() != 0) begin
            chk("queue_drain", exp_q.size(), 32'd0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
